// File: rtl/fmap_addr_gen_pkg.sv
// Shared definitions for the feature-map address sequencer.
//   FMEM_ADDR_WIDTH : default width of feature-memory addresses
//   CNT_WIDTH       : default width of W/H counts and strides
//   ST_*            : FSM state encodings (kept as plain 2-bit constants)
package fmap_addr_gen_pkg;

  localparam int FMEM_ADDR_WIDTH = 16;
  localparam int CNT_WIDTH       = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

endpackage

// File: rtl/fmap_addr_gen_if.sv
// Feature-memory read-address channel (valid/ready).
//   addr_valid : producer has an address on fmem_addr
//   addr_ready : consumer accepts the address this cycle
//   fmem_addr  : read address
//   addr_last  : final address of the sequence
interface fmap_addr_gen_if #(
  parameter int ADDR_W = 16
);

  logic              addr_valid;
  logic              addr_ready;
  logic [ADDR_W-1:0] fmem_addr;
  logic              addr_last;

  modport master (
    output addr_valid,
    output fmem_addr,
    output addr_last,
    input  addr_ready
  );

  modport slave (
    input  addr_valid,
    input  fmem_addr,
    input  addr_last,
    output addr_ready
  );

endinterface

// File: rtl/fmap_idx_cnt.sv
// 2-D nested index counter (columns inner, rows outer).
//   clk, rst : clock, synchronous active-high reset
//   clear    : restart both indices at zero
//   advance  : step to the next position in raster order
//   w_max    : last column index (W_count-1)
//   h_max    : last row index (H_count-1)
//   w_last   : column index is at w_max
//   h_last   : row index is at h_max
module fmap_idx_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  input  logic [CNT_W-1:0] w_max,
  input  logic [CNT_W-1:0] h_max,
  output logic             w_last,
  output logic             h_last
);

  logic [CNT_W-1:0] w_idx;
  logic [CNT_W-1:0] h_idx;

  assign w_last = (w_idx == w_max);
  assign h_last = (h_idx == h_max);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      w_idx <= '0;
      h_idx <= '0;
    end else if (advance) begin
      if (!w_last) begin
        w_idx <= w_idx + CNT_W'(1);
      end else begin
        w_idx <= '0;
        // wrap the row index too after the final beat so the counter is
        // self-consistent even if advanced past the end
        h_idx <= h_last ? '0 : h_idx + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fmap_addr_gen.sv
// Feature-map address sequencer for the matrix-MAC operation.
// Captures geometry and base address on start, then streams raster-ordered
// feature-memory read addresses over a valid/ready channel.
//   clk, rst          : clock, synchronous active-high reset
//   start             : one-cycle pulse, samples the configuration
//   abort             : cancels a running sequence (no done pulse)
//   W_count, H_count  : columns per row, rows
//   W_stride, H_stride: address step between columns / rows
//   base_addr         : feature-map base address
//   fmem              : address channel (master side)
//   busy              : sequence in progress
//   done              : one-cycle pulse on normal completion
//
// state | meaning
// IDLE  | waiting for start
// RUN   | streaming addresses
// FIN   | completion, done asserted for this one cycle
module fmap_addr_gen
  import fmap_addr_gen_pkg::*;
#(
  parameter int ADDR_W = FMEM_ADDR_WIDTH,
  parameter int CNT_W  = CNT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [CNT_W-1:0]        W_count,
  input  logic [CNT_W-1:0]        H_count,
  input  logic [CNT_W-1:0]        W_stride,
  input  logic [CNT_W-1:0]        H_stride,
  input  logic [ADDR_W-1:0]       base_addr,
  fmap_addr_gen_if.master         fmem,
  output logic                    busy,
  output logic                    done
);

  logic [1:0]        state;
  logic [CNT_W-1:0]  w_max;
  logic [CNT_W-1:0]  h_max;
  logic [ADDR_W-1:0] w_step;
  logic [ADDR_W-1:0] h_step;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] addr_q;
  logic              valid_q;
  logic              w_last;
  logic              h_last;
  logic              fire;
  logic              launch;
  logic [ADDR_W-1:0] row_next;

  assign fire     = valid_q & fmem.addr_ready;
  assign launch   = (state == ST_IDLE) & start;
  assign row_next = row_base + h_step;

  fmap_idx_cnt #(
    .CNT_W (CNT_W)
  ) u_idx_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (launch),
    .advance ((state == ST_RUN) & fire & ~abort),
    .w_max   (w_max),
    .h_max   (h_max),
    .w_last  (w_last),
    .h_last  (h_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      w_max    <= '0;
      h_max    <= '0;
      w_step   <= '0;
      h_step   <= '0;
      row_base <= '0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            w_max  <= W_count - CNT_W'(1);
            h_max  <= H_count - CNT_W'(1);
            w_step <= ADDR_W'(W_stride);
            h_step <= ADDR_W'(H_stride);
            if ((W_count == '0) || (H_count == '0)) begin
              state <= ST_FIN;
            end else begin
              row_base <= base_addr;
              addr_q   <= base_addr;
              valid_q  <= 1'b1;
              state    <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            valid_q <= 1'b0;
            state   <= ST_IDLE;
          end else if (fire) begin
            if (!w_last) begin
              addr_q <= addr_q + w_step;
            end else if (!h_last) begin
              row_base <= row_next;
              addr_q   <= row_next;
            end else begin
              valid_q <= 1'b0;
              state   <= ST_FIN;
            end
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign fmem.addr_valid = valid_q;
  assign fmem.fmem_addr  = addr_q;
  assign fmem.addr_last  = valid_q & w_last & h_last;

  assign busy = (state == ST_RUN);
  // an abort landing in FIN cancels the completion pulse
  assign done = (state == ST_FIN) & ~abort;

endmodule

// File: tb/tb_fmap_addr_gen.sv
module tb_fmap_addr_gen;

  typedef struct {
    logic [15:0] addr;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] W_count = '0;
  logic [15:0] H_count = '0;
  logic [15:0] W_stride = '0;
  logic [15:0] H_stride = '0;
  logic [15:0] base_addr = '0;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_done_cyc = -1;

  beat_t sb[$];

  logic        prev_stall = 1'b0;
  logic [15:0] prev_addr  = '0;
  logic        prev_last  = 1'b0;

  fmap_addr_gen_if #(.ADDR_W(16)) bus ();

  fmap_addr_gen #(
    .ADDR_W (16),
    .CNT_W  (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .W_count   (W_count),
    .H_count   (H_count),
    .W_stride  (W_stride),
    .H_stride  (H_stride),
    .base_addr (base_addr),
    .fmem      (bus.master),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input int w, input int h, input int ws, input int hs, input int b);
    beat_t e;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        e.addr = 16'(b + r * hs + c * ws);
        e.last = (r == h - 1) && (c == w - 1);
        sb.push_back(e);
      end
    end
  endtask

  task automatic do_start(input int w, input int h, input int ws, input int hs, input int b);
    W_count   = 16'(w);
    H_count   = 16'(h);
    W_stride  = 16'(ws);
    H_stride  = 16'(hs);
    base_addr = 16'(b);
    push_seq(w, h, ws, hs, b);
    if (w == 0 || h == 0) exp_done_cyc = cyc + 1;
    start = 1'b1;
    step();
    start = 1'b0;
    // scramble config after capture; the running sequence must not notice
    W_count   = 16'hDEAD;
    H_count   = 16'h0007;
    W_stride  = 16'h0333;
    H_stride  = 16'h0444;
    base_addr = 16'h7777;
  endtask

  // toggle=1 gives the ready pattern 1,0,0,1,0,0,...
  task automatic drain(input bit toggle, input int max_cyc);
    int n = 0;
    while (busy && n < max_cyc) begin
      bus.addr_ready = toggle ? ((n % 3) == 0) : 1'b1;
      step();
      n++;
    end
    chk("timeout_busy", {31'b0, busy}, 0);
    bus.addr_ready = 1'b1;
    step();
    step();
    chk("sb_empty", sb.size(), 0);
  endtask

  // monitor: transfers, stall stability and done timing
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {31'b0, bus.addr_valid}, 1);
        chk("hold_addr", {16'b0, bus.fmem_addr}, {16'b0, prev_addr});
        chk("hold_last", {31'b0, bus.addr_last}, {31'b0, prev_last});
      end
      if (bus.addr_valid && bus.addr_ready) begin
        if (sb.size() == 0) begin
          chk("extra_beat", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("addr", {16'b0, bus.fmem_addr}, {16'b0, e.addr});
          chk("last", {31'b0, bus.addr_last}, {31'b0, e.last});
          if (e.last) exp_done_cyc = cyc + 1;
        end
      end
      if (done) begin
        chk("done_cyc", cyc, exp_done_cyc);
        exp_done_cyc = -1;
      end
      prev_stall = bus.addr_valid && !bus.addr_ready && !abort;
      prev_addr  = bus.fmem_addr;
      prev_last  = bus.addr_last;
    end
  end

  initial begin
    bus.addr_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", {31'b0, bus.addr_valid}, 0);
    chk("rst_addr", {16'b0, bus.fmem_addr}, 0);
    chk("rst_last", {31'b0, bus.addr_last}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);

    // basic raster, full throughput
    bus.addr_ready = 1'b1;
    do_start(3, 2, 1, 16, 'h100);
    chk("lat_valid", {31'b0, bus.addr_valid}, 1);
    chk("lat_addr", {16'b0, bus.fmem_addr}, 'h100);
    chk("lat_busy", {31'b0, busy}, 1);
    drain(1'b0, 50);

    // same geometry with backpressure
    do_start(3, 2, 1, 16, 'h100);
    drain(1'b1, 100);

    // empty geometry: no beats, done the cycle after start
    do_start(0, 5, 1, 1, 'h40);
    chk("zero_valid", {31'b0, bus.addr_valid}, 0);
    chk("zero_busy", {31'b0, busy}, 0);
    step();
    step();
    chk("zero_sb", sb.size(), 0);

    // address wrap
    do_start(4, 1, 1, 0, 'hFFFE);
    drain(1'b0, 50);

    // abort after two beats, then a fresh single-beat run
    bus.addr_ready = 1'b1;
    do_start(4, 4, 1, 4, 0);
    step();
    step();
    abort = 1'b1;
    bus.addr_ready = 1'b0;
    step();
    abort = 1'b0;
    chk("abort_valid", {31'b0, bus.addr_valid}, 0);
    chk("abort_last", {31'b0, bus.addr_last}, 0);
    chk("abort_busy", {31'b0, busy}, 0);
    chk("abort_left", sb.size(), 14);
    sb.delete();
    step();
    step();
    bus.addr_ready = 1'b1;
    do_start(1, 1, 0, 0, 'h20);
    chk("single_addr", {16'b0, bus.fmem_addr}, 'h20);
    chk("single_last", {31'b0, bus.addr_last}, 1);
    drain(1'b0, 20);

    // start during RUN is ignored
    bus.addr_ready = 1'b0;
    do_start(3, 2, 1, 16, 'h100);
    step();
    W_count   = 16'd1;
    H_count   = 16'd1;
    base_addr = 16'h0500;
    start = 1'b1;
    bus.addr_ready = 1'b1;
    step();
    start = 1'b0;
    drain(1'b0, 50);

    // reset together with start mid-RUN
    bus.addr_ready = 1'b0;
    do_start(3, 2, 1, 16, 'h100);
    step();
    rst   = 1'b1;
    start = 1'b1;
    step();
    rst   = 1'b0;
    start = 1'b0;
    chk("mrst_valid", {31'b0, bus.addr_valid}, 0);
    chk("mrst_addr", {16'b0, bus.fmem_addr}, 0);
    chk("mrst_last", {31'b0, bus.addr_last}, 0);
    chk("mrst_busy", {31'b0, busy}, 0);
    chk("mrst_done", {31'b0, done}, 0);
    sb.delete();
    exp_done_cyc = -1;
    step();
    step();
    chk("mrst_idle", {31'b0, busy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
